// File: rtl/sketch_pkg.sv
// Shared types and helpers for the sketch counter datapath.
// Row id width and saturating increment live here for reuse.
package sketch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  function automatic int row_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input int          w
  );
    logic [31:0] m;
    m = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= m) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sketch_fwd_hist.sv
// Two-entry write history used to forward over in-flight writes.
// Entries shift every cycle, so each one lives exactly two cycles.
module sketch_fwd_hist #(
  parameter int AW = 10,
  parameter int CW = 16,
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          inval,
  input  logic [DW-1:0] push_dst,
  input  logic [AW-1:0] push_addr,
  input  logic [CW-1:0] push_data,
  input  logic [DW-1:0] look_dst,
  input  logic [AW-1:0] look_addr,
  output logic          hit,
  output logic [CW-1:0] hit_data
);

  typedef struct packed {
    logic          v;
    logic [DW-1:0] dst;
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
  } ent_t;

  ent_t h0, h1;
  logic m0, m1;

  assign m0 = h0.v && h0.dst == look_dst &&
              h0.addr == look_addr;
  assign m1 = h1.v && h1.dst == look_dst &&
              h1.addr == look_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h0 <= '0;
      h1 <= '0;
    end else if (inval) begin
      h0 <= '0;
      h1 <= '0;
    end else begin
      h1 <= h0;
      if (push)
        h0 <= '{v: 1'b1, dst: push_dst,
                addr: push_addr, data: push_data};
      else
        h0 <= '0;
    end
  end

  // Youngest entry wins when both match.
  always_comb begin
    hit      = 1'b0;
    hit_data = h1.data;
    if (m0) begin
      hit      = 1'b1;
      hit_data = h0.data;
    end else if (m1) begin
      hit = 1'b1;
    end
  end

endmodule

// File: rtl/sketch_counter_update.sv
// Read-modify-write stage: saturating increment, RAW forwarding,
// hot-entry reporting and a full-memory clear sweep.
module sketch_counter_update
  import sketch_pkg::*;
#(
  parameter  int ADDR_WIDTH_FULL = 10,
  parameter  int CNT_WIDTH       = 16,
  parameter  int PIPELINE_DEPTH  = 4,
  localparam int DW = row_w(PIPELINE_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [ADDR_WIDTH_FULL-1:0] addr_in,
  input  logic                       rd_en_in,
  input  logic [DW-1:0]              dst_id_in,
  input  logic [CNT_WIDTH-1:0]       rd_data_in,
  input  logic                       rd_cnt_in,
  input  logic [CNT_WIDTH-1:0]       threshold,
  input  logic                       clear_req,
  output logic                       wr_en,
  output logic [ADDR_WIDTH_FULL-1:0] wr_addr,
  output logic [DW-1:0]              wr_dst_id,
  output logic [CNT_WIDTH-1:0]       wr_data,
  output logic                       hot_valid,
  output logic [ADDR_WIDTH_FULL-1:0] hot_addr,
  output logic [DW-1:0]              hot_dst_id,
  output logic [CNT_WIDTH-1:0]       hot_cnt,
  output logic                       q_valid,
  output logic [CNT_WIDTH-1:0]       q_cnt,
  output logic                       clear_busy
);

  state_t                     state;
  logic [DW-1:0]              sw_row;
  logic [ADDR_WIDTH_FULL-1:0] sw_idx;
  logic                       sw_last;
  logic                       inc;
  logic                       hot;
  logic                       hit;
  logic [CNT_WIDTH-1:0]       hit_data;
  logic [CNT_WIDTH-1:0]       old_cnt;
  logic [CNT_WIDTH-1:0]       new_cnt;

  assign inc     = state == RUN && rd_en_in && rd_cnt_in;
  assign old_cnt = hit ? hit_data : rd_data_in;
  assign new_cnt = CNT_WIDTH'(sat_inc(32'(old_cnt), CNT_WIDTH));
  assign hot     = inc && threshold != '0 &&
                   new_cnt == threshold && old_cnt < threshold;
  assign sw_last = sw_row == DW'(PIPELINE_DEPTH - 1) && (&sw_idx);

  sketch_fwd_hist #(
    .AW(ADDR_WIDTH_FULL),
    .CW(CNT_WIDTH),
    .DW(DW)
  ) u_hist (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (inc),
    .inval    (state == CLEAR && sw_last),
    .push_dst (dst_id_in),
    .push_addr(addr_in),
    .push_data(new_cnt),
    .look_dst (dst_id_in),
    .look_addr(addr_in),
    .hit      (hit),
    .hit_data (hit_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      sw_row     <= '0;
      sw_idx     <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_dst_id  <= '0;
      wr_data    <= '0;
      hot_valid  <= 1'b0;
      hot_addr   <= '0;
      hot_dst_id <= '0;
      hot_cnt    <= '0;
      q_valid    <= 1'b0;
      q_cnt      <= '0;
      clear_busy <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      hot_valid <= 1'b0;
      q_valid   <= 1'b0;
      unique case (state)
        RUN: begin
          clear_busy <= 1'b0;
          if (inc) begin
            wr_en     <= 1'b1;
            wr_addr   <= addr_in;
            wr_dst_id <= dst_id_in;
            wr_data   <= new_cnt;
          end
          if (rd_en_in && !rd_cnt_in) begin
            q_valid <= 1'b1;
            q_cnt   <= old_cnt;
          end
          if (hot) begin
            hot_valid  <= 1'b1;
            hot_addr   <= addr_in;
            hot_dst_id <= dst_id_in;
            hot_cnt    <= new_cnt;
          end
          if (clear_req) begin
            state  <= CLEAR;
            sw_row <= '0;
            sw_idx <= '0;
          end
        end
        CLEAR: begin
          wr_en      <= 1'b1;
          wr_addr    <= sw_idx;
          wr_dst_id  <= sw_row;
          wr_data    <= '0;
          clear_busy <= 1'b1;
          if (sw_last) begin
            state  <= RUN;
            sw_row <= '0;
            sw_idx <= '0;
          end else begin
            {sw_row, sw_idx} <= {sw_row, sw_idx} + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sketch_counter_update.sv
// Scoreboard bench for sketch_counter_update: directed cases
// followed by random traffic against a true-count model.
module tb_sketch_counter_update;

  localparam int AW   = 3;
  localparam int CW   = 16;
  localparam int DEP  = 2;
  localparam int DW   = 1;
  localparam int NA   = 1 << AW;
  localparam int NSW  = DEP * NA;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] addr_in;
  logic          rd_en_in;
  logic [DW-1:0] dst_id_in;
  logic [CW-1:0] rd_data_in;
  logic          rd_cnt_in;
  logic [CW-1:0] threshold;
  logic          clear_req;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_dst_id;
  logic [CW-1:0] wr_data;
  logic          hot_valid;
  logic [AW-1:0] hot_addr;
  logic [DW-1:0] hot_dst_id;
  logic [CW-1:0] hot_cnt;
  logic          q_valid;
  logic [CW-1:0] q_cnt;
  logic          clear_busy;

  always #5 clk = ~clk;

  sketch_counter_update #(
    .ADDR_WIDTH_FULL(AW),
    .CNT_WIDTH      (CW),
    .PIPELINE_DEPTH (DEP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .addr_in   (addr_in),
    .rd_en_in  (rd_en_in),
    .dst_id_in (dst_id_in),
    .rd_data_in(rd_data_in),
    .rd_cnt_in (rd_cnt_in),
    .threshold (threshold),
    .clear_req (clear_req),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_dst_id (wr_dst_id),
    .wr_data   (wr_data),
    .hot_valid (hot_valid),
    .hot_addr  (hot_addr),
    .hot_dst_id(hot_dst_id),
    .hot_cnt   (hot_cnt),
    .q_valid   (q_valid),
    .q_cnt     (q_cnt),
    .clear_busy(clear_busy)
  );

  typedef struct {
    int row;
    int addr;
    int data;
    int c;
  } ev_t;

  ev_t wr_q[$];
  ev_t hot_q[$];
  int  q_q[$];
  ev_t pend[$];

  int checks    = 0;
  int failures  = 0;
  int busy_cyc  = 0;
  int cyc       = 0;
  int true_v [DEP][NA];
  int mem_vis[DEP][NA];

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    int  v;
    if (clear_busy) busy_cyc++;
    if (wr_en) begin
      if (wr_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_unexpected: got row %0d addr %0d data %0d expected none",
                 wr_dst_id, wr_addr, wr_data);
      end else begin
        e = wr_q.pop_front();
        chk("wr_dst_id", wr_dst_id, e.row);
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_data", wr_data, e.data);
      end
    end
    if (hot_valid) begin
      if (hot_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL hot_unexpected: got cnt %0d expected none", hot_cnt);
      end else begin
        e = hot_q.pop_front();
        chk("hot_dst_id", hot_dst_id, e.row);
        chk("hot_addr", hot_addr, e.addr);
        chk("hot_cnt", hot_cnt, e.data);
      end
    end
    if (q_valid) begin
      if (q_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL q_unexpected: got %0d expected none", q_cnt);
      end else begin
        v = q_q.pop_front();
        chk("q_cnt", q_cnt, v);
      end
    end
  end

  task automatic issue(input bit en, input bit cnt, input bit clr,
                       input int row, input int addr, input int data);
    rd_en_in   = en;
    rd_cnt_in  = cnt;
    clear_req  = clr;
    dst_id_in  = DW'(row);
    addr_in    = AW'(addr);
    rd_data_in = CW'(data);
    @(posedge clk);
    #1;
    rd_en_in  = 1'b0;
    clear_req = 1'b0;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(0, 0, 0, 0, 0, 0);
  endtask

  task automatic expw(input int row, input int addr, input int data);
    wr_q.push_back('{row, addr, data, 0});
  endtask

  // Memory lags writes by three access cycles; the DUT must hide that.
  task automatic access(input int row, input int addr, input bit cnt);
    int rd, old, nw, thr;
    while (pend.size() > 0 && pend[0].c <= cyc - 3) begin
      ev_t p = pend.pop_front();
      mem_vis[p.row][p.addr] = p.data;
    end
    rd  = mem_vis[row][addr];
    old = true_v[row][addr];
    thr = int'(threshold);
    if (cnt) begin
      nw = (old == CMAX) ? old : old + 1;
      expw(row, addr, nw);
      if (thr != 0 && nw == thr && old < thr)
        hot_q.push_back('{row, addr, nw, 0});
      true_v[row][addr] = nw;
      pend.push_back('{row, addr, nw, cyc});
    end else begin
      q_q.push_back(old);
    end
    issue(1, cnt, 0, row, addr, rd);
  endtask

  task automatic sweep_exp(input int n);
    for (int i = 0; i < n; i++) expw(i / NA, i % NA, 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    rd_en_in   = 1'b0;
    rd_cnt_in  = 1'b0;
    clear_req  = 1'b0;
    dst_id_in  = '0;
    addr_in    = '0;
    rd_data_in = '0;
    threshold  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_hot_valid", hot_valid, 0);
    chk("rst_q_valid", q_valid, 0);
    chk("rst_clear_busy", clear_busy, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    expw(1, 5, 8);
    issue(1, 1, 0, 1, 5, 7);
    idle(3);

    expw(0, 3, 1); expw(0, 3, 2); expw(0, 3, 3);
    repeat (3) issue(1, 1, 0, 0, 3, 0);
    idle(2);
    expw(0, 3, 4);
    issue(1, 1, 0, 0, 3, 3);
    idle(3);

    threshold = 16'd10;
    expw(0, 4, CMAX);
    issue(1, 1, 0, 0, 4, CMAX);
    expw(1, 6, 10);
    hot_q.push_back('{1, 6, 10, 0});
    issue(1, 1, 0, 1, 6, 9);
    idle(3);
    expw(1, 6, 11);
    issue(1, 1, 0, 1, 6, 10);
    idle(3);
    threshold = '0;

    expw(0, 6, 21);
    issue(1, 1, 0, 0, 6, 20);
    q_q.push_back(42);
    issue(1, 0, 0, 1, 2, 42);
    expw(0, 6, 22);
    issue(1, 1, 0, 0, 6, 0);
    idle(3);

    busy_cyc = 0;
    expw(1, 7, 31);
    sweep_exp(NSW);
    issue(1, 1, 1, 1, 7, 30);
    for (int i = 0; i < NSW; i++)
      issue(1, $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, DEP - 1), $urandom_range(0, NA - 1),
            $urandom_range(0, 100));
    idle(3);
    chk("busy_cycles", busy_cyc, NSW);

    sweep_exp(3);
    issue(0, 0, 1, 0, 0, 0);
    idle(3);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_wr_en", wr_en, 0);
    chk("abort_wr_addr", wr_addr, 0);
    chk("abort_wr_dst_id", wr_dst_id, 0);
    chk("abort_clear_busy", clear_busy, 0);
    chk("abort_hot_valid", hot_valid, 0);
    chk("abort_q_valid", q_valid, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    expw(0, 2, 51);
    issue(1, 1, 0, 0, 2, 50);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    expw(0, 2, 8);
    issue(1, 1, 0, 0, 2, 7);
    idle(3);

    sweep_exp(NSW);
    issue(0, 0, 1, 0, 0, 0);
    idle(NSW + 4);
    for (int r = 0; r < DEP; r++)
      for (int a = 0; a < NA; a++) begin
        true_v[r][a]  = 0;
        mem_vis[r][a] = 0;
      end
    pend.delete();
    threshold = 16'd3;

    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2)
        idle(1);
      else
        access($urandom_range(0, DEP - 1), $urandom_range(0, 3),
               r < 8);
    end
    idle(4);

    chk("wr_q_drained", wr_q.size(), 0);
    chk("hot_q_drained", hot_q.size(), 0);
    chk("q_q_drained", q_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sketch_counter_update.md
# sketch_counter_update

Read-modify-write stage of the sketch datapath, sitting directly downstream of the pipelined memory read buffer. It takes the registered read response (address, row id, old counter value, count flag) and computes the new saturating counter value. It forwards over the two most recent writes to hide read-after-write hazards, writes the result back to the row memory, and flags hot entries whose count reaches a programmable threshold. A built-in sweep FSM zeroes every counter of every row on request.

## Interface
Parameters:
- ADDR_WIDTH_FULL, 10, counter index width per row.
- CNT_WIDTH, 16, counter width; equals the row memory data width.
- PIPELINE_DEPTH, 4, number of sketch rows (≥2); row id width is DW = $clog2(PIPELINE_DEPTH).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous active-low reset.
- addr_in  in  ADDR_WIDTH_FULL  counter index of the returning read.
- rd_en_in  in  1  response valid this cycle.
- dst_id_in  in  DW  row id of the response.
- rd_data_in  in  CNT_WIDTH  counter value read from memory (may be stale).
- rd_cnt_in  in  1  1 = increment; 0 = query only (no write).
- threshold  in  CNT_WIDTH  hot threshold; 0 disables reporting.
- clear_req  in  1  single-cycle pulse that starts the sweep.
- wr_en  out  1  row memory write strobe.
- wr_addr  out  ADDR_WIDTH_FULL  write index.
- wr_dst_id  out  DW  row being written.
- wr_data  out  CNT_WIDTH  write value.
- hot_valid  out  1  single-cycle hot report.
- hot_addr / hot_dst_id / hot_cnt  out  ADDR_WIDTH_FULL / DW / CNT_WIDTH  report payload.
- q_valid / q_cnt  out  1 / CNT_WIDTH  result of a query-only access.
- clear_busy  out  1  sweep in progress; upstream stalls issue.

## Operation
- FSM states: RUN (reset state) and CLEAR.
- RUN, rd_en_in=1:
  - Effective old value = youngest matching history entry on {dst_id, addr}; otherwise rd_data_in.
  - rd_cnt_in=1: new = old+1, saturating at 2^CNT_WIDTH−1. Write back the new value and push {dst_id, addr, new} into the history.
  - rd_cnt_in=0: q_valid=1, q_cnt=old. No write, no history push.
- History holds the 2 most recent writes, newest first. Memory write-to-read visibility is 3 cycles, so 2 entries cover the hazard window. Entries age out after 2 cycles with no new writes; an invalid entry never matches.
- Hot report: hot_valid=1 when threshold≠0, the access is an increment, and new==threshold with old<threshold. Each counter therefore reports once per epoch. Saturation never reports unless threshold equals the maximum value.
- clear_req in RUN: next cycle enter CLEAR and start sweep counter {row, index} at 0. Each cycle write 0 to it and increment. Leave for RUN after the last entry {PIPELINE_DEPTH−1, 2^ADDR_WIDTH_FULL−1}. History is invalidated on exit.
- In CLEAR, rd_en_in and clear_req are ignored; no q_valid or hot_valid is produced.
- clear_req on the same cycle as rd_en_in: the access is processed normally, then the clear starts.

## Timing
- All outputs are registered. Latency is 1 cycle: an input in cycle t produces wr_*, hot_*, and q_* in cycle t+1.
- Throughput is one access per cycle with no stalls in RUN.
- Sweep length is PIPELINE_DEPTH·2^ADDR_WIDTH_FULL write cycles. clear_busy is high from the cycle after clear_req through the last sweep write.
- Reset values: all outputs 0, FSM in RUN, history invalid, sweep counter 0.
- Reset asserted mid-sweep aborts the sweep immediately. Counters are left partially cleared; software reissues clear_req.

## Structure
- Package sketch_pkg holds the state enum (RUN, CLEAR), the row id width function, and a sat_inc function.
- One sub-module, sketch_fwd_hist: the 2-entry write history with valid bits, push and invalidate inputs, and a youngest-match lookup output.

## Test plan
- Single increment: addr=5, row=1, rd_data=7, rd_cnt=1 → next cycle wr_en=1, wr_addr=5, wr_dst_id=1, wr_data=8.
- Back-to-back hazard: three increments to row 0, addr 3, all with stale rd_data=0 → wr_data 1, 2, 3 on consecutive cycles. A fourth access 3 cycles later with rd_data=3 → 4.
- Saturation and hot: CNT_WIDTH=16, rd_data=0xFFFF → wr_data=0xFFFF, no hot. Threshold=10 with rd_data=9 → hot_valid=1, hot_cnt=10. Same addr with rd_data=10 → no hot.
- Query: rd_cnt=0, rd_data=42 → q_valid=1, q_cnt=42, wr_en=0, history unchanged.
- Clear: ADDR_WIDTH_FULL=2, PIPELINE_DEPTH=2, clear_req → 8 zero writes in order (0,0)…(1,3). clear_busy is high for exactly 8 cycles, and rd_en_in during the sweep is ignored.
- Reset at sweep write 3 → all outputs 0 and FSM in RUN. The next increment uses rd_data unforwarded.
